// File: rtl/down_timer.sv
// down_timer: loadable down-counter emitting a one-cycle expire pulse, with
// one-shot/periodic modes, pause/resume and a fixed clock prescaler.
module down_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             paused,
  output logic             expire
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  state_t         state;
  logic [WIDTH-1:0] rld;
  logic [PW-1:0]  pre;
  logic           tick;
  assign tick = state == RUN && pre == PW'(PRESCALE - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rld    <= '0;
      pre    <= '0;
      busy   <= 1'b0;
      paused <= 1'b0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      // a command only consumes the cycle when it acts in the current state
      if (stop && state != IDLE) begin
        if (state == RUN) begin
          state  <= PAUSED;
          paused <= 1'b1;
        end else begin
          state  <= IDLE;
          cnt    <= '0;
          busy   <= 1'b0;
          paused <= 1'b0;
        end
      end else if (load) begin
        rld <= load_val;
        cnt <= load_val;
        pre <= '0;
      end else if (start && state != RUN) begin
        if (state == PAUSED) begin
          state  <= RUN;
          paused <= 1'b0;
        end else if (rld != '0) begin
          cnt   <= rld;
          pre   <= '0;
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          expire <= 1'b1;
        end
      end else if (state == RUN) begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick) begin
          if (cnt > WIDTH'(1)) begin
            cnt <= cnt - 1'b1;
          end else begin
            // cnt==0 here only after a load of 0 while running; treat as terminal
            expire <= 1'b1;
            cnt    <= mode ? rld : '0;
            if (!mode) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: drives a PRESCALE=1 and a PRESCALE=3 timer with shared stimulus
// and compares both against a cycle-level reference model every clock.
module tb_down_timer;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] cnt1, cnt3;
  logic busy1, busy3, paused1, paused3, exp1, exp3;
  int checks = 0, errors = 0;
  int m_st[2], m_cnt[2], m_rld[2], m_pre[2], m_exp[2];
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(8), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .mode(mode), .cnt(cnt1), .busy(busy1), .paused(paused1), .expire(exp1));
  down_timer #(.WIDTH(8), .PRESCALE(3)) u3 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .mode(mode), .cnt(cnt3), .busy(busy3), .paused(paused3), .expire(exp3));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: apply the command priority rules to one timer with prescale p
  task automatic model(input int k, input int p);
    m_exp[k] = 0;
    if (!rst) begin
      m_st[k] = M_IDLE; m_cnt[k] = 0; m_rld[k] = 0; m_pre[k] = 0;
    end else if (stop && m_st[k] != M_IDLE) begin
      if (m_st[k] == M_RUN) m_st[k] = M_PAUSED;
      else begin m_st[k] = M_IDLE; m_cnt[k] = 0; end
    end else if (load) begin
      m_rld[k] = load_val; m_cnt[k] = load_val; m_pre[k] = 0;
    end else if (start && m_st[k] != M_RUN) begin
      if (m_st[k] == M_PAUSED) m_st[k] = M_RUN;
      else if (m_rld[k] == 0) m_exp[k] = 1;
      else begin m_cnt[k] = m_rld[k]; m_pre[k] = 0; m_st[k] = M_RUN; end
    end else if (m_st[k] == M_RUN) begin
      m_pre[k] = (m_pre[k] + 1) % p;
      if (m_pre[k] == 0) begin
        if (m_cnt[k] > 1) m_cnt[k] -= 1;
        else begin
          m_exp[k] = 1;
          m_cnt[k] = mode ? m_rld[k] : 0;
          if (!mode) m_st[k] = M_IDLE;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model(0, 1);
    model(1, 3);
    @(negedge clk);
    chk("cnt1", cnt1, m_cnt[0]);
    chk("busy1", busy1, int'(m_st[0] != M_IDLE));
    chk("paused1", paused1, int'(m_st[0] == M_PAUSED));
    chk("expire1", exp1, m_exp[0]);
    chk("cnt3", cnt3, m_cnt[1]);
    chk("busy3", busy3, int'(m_st[1] != M_IDLE));
    chk("paused3", paused3, int'(m_st[1] == M_PAUSED));
    chk("expire3", exp3, m_exp[1]);
  endtask

  task automatic cyc(input logic ld, input int lv, input logic st, input logic sp);
    load = ld; load_val = 8'(lv); start = st; stop = sp;
    step();
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    int pulses;
    @(negedge clk);
    step(); step();
    chk("rst_cnt", cnt1, 0);
    chk("rst_busy", busy3, 0);
    rst = 1'b1;
    // one-shot N=5, PRESCALE=1
    mode = 1'b0;
    cyc(1, 5, 0, 0);
    cyc(0, 0, 1, 0);
    chk("os_cnt0", cnt1, 5);
    chk("os_busy0", busy1, 1);
    for (int e = 1; e <= 4; e++) begin
      cyc(0, 0, 0, 0);
      chk("os_cnt", cnt1, 5 - e);
      chk("os_noexp", exp1, 0);
    end
    cyc(0, 0, 0, 0);
    chk("os_exp", exp1, 1);
    chk("os_idle", busy1, 0);
    chk("os_cnt_end", cnt1, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    // periodic N=4: PRESCALE=3 pulses every 12, PRESCALE=1 every 4
    mode = 1'b1;
    cyc(1, 4, 0, 0);
    cyc(0, 0, 1, 0);
    pulses = 0;
    for (int e = 1; e <= 36; e++) begin
      cyc(0, 0, 0, 0);
      pulses += int'(exp3);
      if (e % 12 == 0) chk("per_exp3", exp3, 1);
      if (e % 12 == 0) chk("per_cnt3", cnt3, 4);
    end
    chk("per_pulses3", pulses, 3);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("abort_cnt", cnt3, 0);
    chk("abort_busy", busy3, 0);
    // pause/resume: stop at edge 3, start at edge 6, expire at edge 10
    mode = 1'b0;
    cyc(1, 6, 0, 0);
    cyc(0, 0, 1, 0);
    for (int e = 1; e <= 12; e++) begin
      cyc(0, 0, e == 6, e == 3);
      if (e >= 3 && e < 6) chk("pause_flag", paused1, 1);
      chk("pause_exp", exp1, int'(e == 10));
    end
    // abort then restart runs the full interval
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("abort2_cnt", cnt1, 0);
    cyc(0, 0, 1, 0);
    chk("restart_cnt", cnt1, 6);
    // stop+start while running: stop wins
    cyc(0, 0, 1, 1);
    chk("conf_paused", paused1, 1);
    cyc(0, 0, 0, 1);
    // load on the terminal tick: load wins
    cyc(1, 2, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("term_cnt1", cnt1, 1);
    cyc(1, 9, 0, 0);
    chk("ldterm_exp", exp1, 0);
    chk("ldterm_cnt", cnt1, 9);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    // zero-length start
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("zero_exp", exp1, 1);
    chk("zero_busy", busy1, 0);
    cyc(0, 0, 0, 0);
    chk("zero_once", exp1, 0);
    // reset on the terminal cycle cancels expire
    cyc(1, 3, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("pre_rst_cnt", cnt1, 1);
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    chk("rst_mid_exp", exp1, 0);
    chk("rst_mid_cnt", cnt1, 0);
    rst = 1'b1;
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      mode = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 7),
          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting timer that sits on the output side of the design's counter infrastructure. Where the up-counters measure how long an input has held, this block generates timed events: it counts a programmed value down to zero and emits a one-cycle `expire` pulse. It supports one-shot and periodic modes, pause/resume, and a fixed clock prescaler, and drives buzzer/LED timing and periodic strobes for the rest of the SoC.

## Interface
- `WIDTH`, 8: bit width of the count and reload value.
- `PRESCALE`, 1: clocks per count tick, ≥1; the internal prescaler width is `$clog2(PRESCALE)`, minimum 1 bit.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low: `rst==0` at a rising edge resets the block.
- `load`  in  1  write `load_val` into the reload register and the count.
- `load_val`  in  WIDTH  reload value.
- `start`  in  1  start from IDLE or resume from PAUSED.
- `stop`  in  1  pause from RUN, or abort from PAUSED.
- `mode`  in  1  0 = one-shot, 1 = periodic; sampled at every terminal tick.
- `cnt`  out  WIDTH  current count, registered.
- `busy`  out  1  state is RUN or PAUSED.
- `paused`  out  1  state is PAUSED.
- `expire`  out  1  one-cycle registered pulse at terminal count.

## Operation
- **Internal state:** FSM state in {IDLE, RUN, PAUSED}, reload register `rld`, prescaler `pre`.
- **Reset values:** `cnt=0`, `rld=0`, `pre=0`, state IDLE, `busy=0`, `paused=0`, `expire=0`.
- **Command priority per cycle:** stop > load > start > tick. Lower-priority requests in the same cycle are dropped, not queued.
- **stop:**
  - In RUN: go to PAUSED; `cnt` and `pre` hold.
  - In PAUSED: go to IDLE and set `cnt=0`.
  - In IDLE: no effect.
- **load (any state):**
  - `rld<=load_val`, `cnt<=load_val`, `pre<=0`.
  - State is unchanged, so a load in RUN restarts the interval.
- **start:**
  - In IDLE with `rld!=0`: `cnt<=rld`, `pre<=0`, go to RUN.
  - In IDLE with `rld==0`: pulse `expire` once and stay IDLE.
  - In PAUSED: return to RUN with `cnt` and `pre` unchanged.
  - In RUN: ignored.
- **Prescaler:**
  - In RUN, `pre` counts 0..PRESCALE-1 and wraps.
  - A tick occurs on a cycle where `pre==PRESCALE-1`.
  - With PRESCALE=1, every RUN cycle is a tick.
- **On a tick:**
  - If `cnt>1`: `cnt<=cnt-1`.
  - If `cnt==1` (terminal): `expire<=1`. In periodic mode, `cnt<=rld` and stay in RUN. In one-shot mode, `cnt<=0` and go to IDLE.
- **Defensive case:** `cnt==0` in RUN (reachable only via load of 0 while RUN) counts as terminal on the next tick and behaves identically.
- **Arithmetic:** unsigned; `cnt` never wraps below 0.
- **expire:** defaults to 0 every cycle unless set by a terminal tick or a zero-length start.

## Timing
- **One-shot, PRESCALE=1, `rld=N`:**
  - `start` sampled at edge 0.
  - After edge 0: `cnt=N`, `busy=1`.
  - After edge N: `expire=1` for exactly one cycle, `busy=0`, `cnt=0`.
- **General PRESCALE:** `expire` rises after edge N·PRESCALE.
- **Periodic:** `expire` pulses every N·PRESCALE cycles with no gap cycle; `cnt` shows N on the cycle `expire` is high.
- **Pause/resume:** a pause of P cycles delays `expire` by exactly P cycles, including any stop and start cycles.
- **Status outputs:** `busy`/`paused` are registered from state and change on the edge that samples the command.
- **Reset mid-run:** all outputs reach reset values after the reset edge; a pending `expire` is cancelled.
- **Same-edge conflicts:**
  - `stop`+`start`: stop wins.
  - `load` with a terminal tick: load wins, so no `expire` and `cnt=load_val`.

## Test plan
- **Reset and one-shot:** reset with `rst=0` for 2 cycles, then `load` 5, `mode=0`, PRESCALE=1, `start` at edge 0 → `cnt` reads 5,4,3,2,1; `expire` high only after edge 5; then `busy=0`, `cnt=0`.
- **Periodic with prescaler:** PRESCALE=3, `load` 4, `mode=1`, start → `expire` pulses every 12 cycles for 3 periods; `cnt` decrements once every 3 clocks; no extra pulse.
- **Pause/resume:** one-shot N=6; `stop` at cycle 3, hold 4 cycles, then `start` → `paused=1` during the hold; `expire` occurs at edge 10.
- **Abort:** stop, then stop again → IDLE with `cnt=0`; a later `start` reloads `rld` and runs the full interval.
- **Conflicts:** `stop`+`start` in the same cycle while RUN → PAUSED. `load` 9 on the terminal-tick cycle → no `expire`, `cnt=9`. `start` with `rld=0` → single `expire`, `busy=0`.
- **Reset mid-run:** `rst=0` at the cycle where `cnt==1` → no `expire`; all outputs 0 next cycle.
